coherence_bus_ctrl: RTL
=======================

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 Parameter: CPUS, 4, number of caches on the bus; legal range 2..8.
REQ-002 Parameter: SNOOP_TO, 16, maximum SNOOP cycles before forced completion; range 1..255.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  in  1  reset, synchronous, active-high.
REQ-005 Ports in, CPUS bits each, one bit per cache: iREN, dREN, dWEN, cctrans, ccwrite, ccack (target snoop lookup done).
REQ-006 Ports in, CPUS x 32 packed: iaddr, daddr, dstore (cache c at bits [32c+31:32c]).
REQ-007 Ports out, CPUS bits each: iwait, dwait, ccwait, ccinv.
REQ-008 Ports out, CPUS x 32 packed: iload, dload, ccsnoopaddr.
REQ-009 Ports: ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-010 Port: snoop_to  out  1  one-cycle pulse when a snoop times out.

Function
REQ-011 Request classes per cache c: WB = dWEN[c]&!cctrans[c]; COH = cctrans[c]; IF = iREN[c] with no WB/COH pending anywhere.
REQ-012 Class priority WB > COH > IF; within a class, round-robin from pointer rr (search rr, rr+1, ... wrapping mod CPUS).
REQ-013 On every grant, rr <= (winner+1) mod CPUS; rr is not updated when no grant occurs.
REQ-014 States: IDLE, WB, SNOOP, C2C, MEMRD, IFETCH; encoding is an implementation choice.
REQ-015 IDLE: all waits 1, ram enables 0; on any request, register init=winner, saddr=daddr[init], inv=ccwrite[init]; go to WB/SNOOP/IFETCH by class next edge (grant latency 1 cycle).
REQ-016 All non-IDLE states: ccwait[t]=1 for every t != init, ccwait[init]=0.
REQ-017 WB: ramWEN=1, ramaddr=daddr[init], ramstore=dstore[init]; dwait[init]=0 only in cycles with ramstate==ACCESS; return to IDLE when dWEN[init]=0.
REQ-018 SNOOP: for all t != init, ccsnoopaddr[t]=saddr, ccinv[t]=inv; snoop counter increments each cycle.
REQ-019 SNOOP exit when ccack[t]=1 for every t != init: if any such t has ccwrite[t]=1, latch supplier = lowest such index and go to C2C, else MEMRD.
REQ-020 SNOOP counter reaching SNOOP_TO before all acks: pulse snoop_to for one cycle, go to MEMRD.
REQ-021 SNOOP with cctrans[init]=0: abandon to IDLE, no RAM access, no rr rollback.
REQ-022 C2C: ramWEN=dWEN[sup], ramaddr=daddr[sup], ramstore=dstore[sup], dload[init]=dstore[sup]; on ACCESS both dwait[init] and dwait[sup] = 0 in the same cycle; exit to IDLE when cctrans[init]=0.
REQ-023 MEMRD: ramREN=dREN[init], ramWEN=dWEN[init], ramaddr=daddr[init], ramstore=dstore[init], dload[init]=ramload; dwait[init]=0 on ACCESS; exit to IDLE when cctrans[init]=0.
REQ-024 IFETCH: ramREN=1, ramaddr=iaddr[init], iload[init]=ramload; iwait[init]=0 on the ACCESS cycle, then IDLE next edge.
REQ-025 ramstate FREE/BUSY/ERROR: all waits held 1, state unchanged, RAM drive held.
REQ-026 Loads to non-selected caches and all unused outputs drive 0.

Reset
REQ-027 RST=1 at a rising edge: state=IDLE, rr=0, init=0, saddr=0, inv=0, counter=0, regardless of current state.
REQ-028 Reset outputs: iwait/dwait all 1, ccwait/ccinv 0, all loads and ccsnoopaddr 0, ramREN/ramWEN 0, ramaddr/ramstore 0, snoop_to 0.

Verification
REQ-029 CPUS=4, iREN=4'b1111 held, ramstate ACCESS every 2nd cycle -> iwait grants in order 0,1,2,3,0.
REQ-030 dWEN[2]=1, cctrans[2]=0 while cctrans[1]=1 -> cache 2 served first (WB), ramaddr=daddr[2].
REQ-031 cctrans[0]=1, ccwrite[0]=1, daddr[0]=0x100; targets ack, ccwrite[3]=1 -> ccinv[1..3]=1, ccsnoopaddr=0x100, C2C with dload[0]=dstore[3].
REQ-032 SNOOP with ccack[2] stuck 0, SNOOP_TO=16 -> snoop_to pulses after 16 cycles, MEMRD entered.
REQ-033 RST asserted mid-C2C -> next edge all outputs at reset values, rr=0.
REQ-034 ramstate=ERROR held in MEMRD -> dwait[init] stays 1, state stays MEMRD.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus arbiter: grants write-backs, coherence transactions and
// instruction fetches to CPUS caches, runs snoops, cache-to-cache transfers and RAM accesses.
module coherence_bus_ctrl #(
  parameter int CPUS     = 4,
  parameter int SNOOP_TO = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  input  logic [CPUS-1:0]      ccack,
  input  logic [CPUS*32-1:0]   iaddr,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 snoop_to
);

  localparam int IW = $clog2(CPUS);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [7:0] TO_LAST    = 8'(SNOOP_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_SNOOP  = 3'd2,
    S_C2C    = 3'd3,
    S_MEMRD  = 3'd4,
    S_IFETCH = 3'd5
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_r;
  logic [IW-1:0]   init_r;
  logic [IW-1:0]   sup_r;
  logic [31:0]     saddr_r;
  logic            inv_r;
  logic [7:0]      cnt_r;
  logic            snoop_to_r;

  logic [CPUS-1:0] wb_req_s;
  logic [CPUS-1:0] init_mask_s;
  logic [IW:0]     wb_pick_s;
  logic [IW:0]     coh_pick_s;
  logic [IW:0]     if_pick_s;
  logic [IW:0]     sup_pick_s;
  logic            grant_hit_s;
  logic [IW-1:0]   grant_idx_s;
  state_t          grant_state_s;
  logic [IW-1:0]   rr_next_s;
  logic            all_ack_s;
  logic            access_s;

  function automatic logic [31:0] word_of(input logic [CPUS*32-1:0] bus, input int idx);
    return bus[32*idx +: 32];
  endfunction

  // Round-robin search starting at ptr; returns {hit, index}.
  function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = {(IW+1){1'b0}};
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CPUS;
      if (req[idx]) res = {1'b1, IW'(idx)};
      else          res = res;
    end
    return res;
  endfunction

  function automatic logic [IW:0] low_pick(input logic [CPUS-1:0] req);
    logic [IW:0] res;
    res = {(IW+1){1'b0}};
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (req[k]) res = {1'b1, IW'(k)};
      else        res = res;
    end
    return res;
  endfunction

  assign wb_req_s   = dWEN & ~cctrans;
  assign wb_pick_s  = rr_pick(wb_req_s, rr_r);
  assign coh_pick_s = rr_pick(cctrans, rr_r);
  assign if_pick_s  = rr_pick(iREN, rr_r);
  assign sup_pick_s = low_pick(ccwrite & ~init_mask_s);
  assign all_ack_s  = &(ccack | init_mask_s);
  assign access_s   = (ramstate == RAM_ACCESS);
  assign rr_next_s  = (int'(grant_idx_s) == CPUS - 1) ? {IW{1'b0}} : grant_idx_s + IW'(1);
  assign snoop_to   = snoop_to_r;

  // One-hot mask of the initiating cache.
  always_comb begin
    init_mask_s = {CPUS{1'b0}};
    init_mask_s[init_r] = 1'b1;
  end

  // Class arbitration: write-back beats coherence beats instruction fetch.
  always_comb begin
    grant_hit_s   = 1'b0;
    grant_idx_s   = {IW{1'b0}};
    grant_state_s = S_IDLE;
    if (|wb_req_s) begin
      grant_hit_s   = wb_pick_s[IW];
      grant_idx_s   = wb_pick_s[IW-1:0];
      grant_state_s = S_WB;
    end else if (|cctrans) begin
      grant_hit_s   = coh_pick_s[IW];
      grant_idx_s   = coh_pick_s[IW-1:0];
      grant_state_s = S_SNOOP;
    end else if (|iREN) begin
      grant_hit_s   = if_pick_s[IW];
      grant_idx_s   = if_pick_s[IW-1:0];
      grant_state_s = S_IFETCH;
    end else begin
      grant_state_s = S_IDLE;
    end
  end

  // Bus state machine, arbitration pointer and snoop bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= S_IDLE;
      rr_r       <= {IW{1'b0}};
      init_r     <= {IW{1'b0}};
      sup_r      <= {IW{1'b0}};
      saddr_r    <= 32'd0;
      inv_r      <= 1'b0;
      cnt_r      <= 8'd0;
      snoop_to_r <= 1'b0;
    end else begin
      snoop_to_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grant_hit_s) begin
            init_r  <= grant_idx_s;
            saddr_r <= word_of(daddr, int'(grant_idx_s));
            inv_r   <= ccwrite[grant_idx_s];
            cnt_r   <= 8'd0;
            rr_r    <= rr_next_s;
            state_r <= grant_state_s;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WB: begin
          if (!dWEN[init_r]) state_r <= S_IDLE;
          else               state_r <= S_WB;
        end
        S_SNOOP: begin
          cnt_r <= cnt_r + 8'd1;
          if (!cctrans[init_r]) begin
            state_r <= S_IDLE;
          end else if (all_ack_s) begin
            if (sup_pick_s[IW]) begin
              sup_r   <= sup_pick_s[IW-1:0];
              state_r <= S_C2C;
            end else begin
              state_r <= S_MEMRD;
            end
          end else if (cnt_r == TO_LAST) begin
            snoop_to_r <= 1'b1;
            state_r    <= S_MEMRD;
          end else begin
            state_r <= S_SNOOP;
          end
        end
        S_C2C, S_MEMRD: begin
          if (!cctrans[init_r]) state_r <= S_IDLE;
          else                  state_r <= state_r;
        end
        S_IFETCH: begin
          if (access_s) state_r <= S_IDLE;
          else          state_r <= S_IFETCH;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the current state and the selected caches.
  always_comb begin
    iwait       = {CPUS{1'b1}};
    dwait       = {CPUS{1'b1}};
    ccwait      = {CPUS{1'b0}};
    ccinv       = {CPUS{1'b0}};
    iload       = {(CPUS*32){1'b0}};
    dload       = {(CPUS*32){1'b0}};
    ccsnoopaddr = {(CPUS*32){1'b0}};
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;
    if (state_r != S_IDLE) ccwait = ~init_mask_s;
    else                   ccwait = {CPUS{1'b0}};
    case (state_r)
      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = word_of(daddr, int'(init_r));
        ramstore = word_of(dstore, int'(init_r));
        if (access_s) dwait[init_r] = 1'b0;
        else          dwait[init_r] = 1'b1;
      end
      S_SNOOP: begin
        ccinv = {CPUS{inv_r}} & ~init_mask_s;
        for (int t = 0; t < CPUS; t++) begin
          if (t != int'(init_r)) ccsnoopaddr[32*t +: 32] = saddr_r;
          else                   ccsnoopaddr[32*t +: 32] = 32'd0;
        end
      end
      S_C2C: begin
        ramWEN   = dWEN[sup_r];
        ramaddr  = word_of(daddr, int'(sup_r));
        ramstore = word_of(dstore, int'(sup_r));
        dload[32*int'(init_r) +: 32] = word_of(dstore, int'(sup_r));
        if (access_s) begin
          dwait[init_r] = 1'b0;
          dwait[sup_r]  = 1'b0;
        end else begin
          dwait = {CPUS{1'b1}};
        end
      end
      S_MEMRD: begin
        ramREN   = dREN[init_r];
        ramWEN   = dWEN[init_r];
        ramaddr  = word_of(daddr, int'(init_r));
        ramstore = word_of(dstore, int'(init_r));
        dload[32*int'(init_r) +: 32] = ramload;
        if (access_s) dwait[init_r] = 1'b0;
        else          dwait[init_r] = 1'b1;
      end
      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = word_of(iaddr, int'(init_r));
        iload[32*int'(init_r) +: 32] = ramload;
        if (access_s) iwait[init_r] = 1'b0;
        else          iwait[init_r] = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule
